// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder evaluation per clock, LSB first, with a registered
// carry between bits. Adds two WIDTH-bit operands in WIDTH cycles plus one result cycle.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_s, fa_co;
  logic accept;

  // The single full-adder cell, reused for every bit position.
  assign fa_s  = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
  assign fa_co = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);

  // A new operation may start from IDLE or directly out of DONE (back-to-back).
  assign accept = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: state_d = IDLE;
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        s_sr_d = {fa_s, s_sr_q[WIDTH-1:1]};
        c_d    = fa_co;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_s, s_sr_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_sr_d  = a;
      b_sr_d  = b;
      c_d     = cin;
      cnt_d   = '0;
      state_d = SHIFT;
    end
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: 8-bit and 4-bit instances checked against
// plain integer addition and the WIDTH-edge latency rule.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int checks   = 0;
  int failures = 0;
  int last_sum [2];
  int last_cout[2];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int obs_busy(input int w);
    return (w == 8) ? int'(busy8) : int'(busy4);
  endfunction
  function automatic int obs_done(input int w);
    return (w == 8) ? int'(done8) : int'(done4);
  endfunction
  function automatic int obs_sum(input int w);
    return (w == 8) ? int'(sum8) : int'(sum4);
  endfunction
  function automatic int obs_cout(input int w);
    return (w == 8) ? int'(cout8) : int'(cout4);
  endfunction

  task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
    if (w == 8) begin
      start8 = st; a8 = a; b8 = b; cin8 = c;
    end else begin
      start4 = st; a4 = a[3:0]; b4 = b[3:0]; cin4 = c;
    end
  endtask

  // One complete addition; when scramble is set, start/a/b/cin churn during the shift phase.
  task automatic run_add(input int w, input logic [7:0] a, input logic [7:0] b, input logic c,
                         input bit scramble, input string tag);
    int mask, total, cycles, busy_cycles, idx;
    idx    = (w == 8) ? 0 : 1;
    mask   = (1 << w) - 1;
    total  = (int'(a) & mask) + (int'(b) & mask) + int'(c);
    cycles = 0;
    busy_cycles = 0;
    @(negedge clk);
    drive(w, 1'b1, a, b, c);
    @(posedge clk);
    for (;;) begin
      @(negedge clk);
      if (obs_done(w) == 1 || cycles >= 4 * w + 8) break;
      busy_cycles += obs_busy(w);
      if (cycles == 0 || scramble)
        check({tag, "_hold"}, obs_sum(w) | (obs_cout(w) << w),
              last_sum[idx] | (last_cout[idx] << w));
      if (scramble)
        drive(w, 1'($urandom_range(1)), 8'($urandom), 8'($urandom), 1'($urandom_range(1)));
      else
        drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom_range(1)));
      @(posedge clk);
      cycles++;
    end
    drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
    check({tag, "_latency"}, cycles, w);
    check({tag, "_busy_cycles"}, busy_cycles, w);
    check({tag, "_busy_in_done"}, obs_busy(w), 0);
    check({tag, "_sum"}, obs_sum(w), total & mask);
    check({tag, "_cout"}, obs_cout(w), total >> w);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, obs_done(w), 0);
    last_sum[idx]  = total & mask;
    last_cout[idx] = total >> w;
  endtask

  initial begin
    int dones, gap;
    last_sum  = '{0, 0};
    last_cout = '{0, 0};

    rst = 1'b1;
    #12;
    check("reset_busy", int'(busy8), 0);
    check("reset_done", int'(done8), 0);
    check("reset_sum", int'(sum8), 0);
    check("reset_cout", int'(cout8), 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases, including full carry ripple and the all-ones boundary.
    run_add(8, 8'h5A, 8'h3C, 1'b0, 1'b0, "d_5a_3c");
    run_add(8, 8'hFF, 8'h01, 1'b0, 1'b0, "d_ff_01");
    run_add(8, 8'hFF, 8'hFF, 1'b1, 1'b0, "d_ff_ff_c");
    run_add(8, 8'h00, 8'h00, 1'b0, 1'b0, "d_zero");

    // start toggles and operand churn during SHIFT are ignored.
    run_add(8, 8'hC3, 8'h7E, 1'b1, 1'b1, "ignore_churn");

    // Back-to-back: start held high, operands changed while busy.
    @(negedge clk);
    drive(8, 1'b1, 8'h10, 8'h20, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b1, 8'h01, 8'h02, 1'b0);
    gap = 0;
    while (done8 !== 1'b1 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_first_sum", int'(sum8), 8'h30);
    check("b2b_first_cout", int'(cout8), 0);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (done8 !== 1'b1 && gap < 40);
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    check("b2b_period", gap, 9);
    check("b2b_second_sum", int'(sum8), 8'h03);
    @(negedge clk);
    check("b2b_idle_after", int'(busy8 | done8), 0);
    last_sum[0]  = 8'h03;
    last_cout[0] = 0;

    // Asynchronous reset in the middle of the 4th shift aborts the operation.
    @(negedge clk);
    drive(8, 1'b1, 8'hAA, 8'h55, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", int'(busy8), 0);
    check("arst_done", int'(done8), 0);
    check("arst_sum", int'(sum8), 0);
    check("arst_cout", int'(cout8), 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      dones += int'(done8);
    end
    check("arst_no_done", dones, 0);
    last_sum[0]  = 0;
    last_cout[0] = 0;
    run_add(8, 8'hAA, 8'h55, 1'b1, 1'b0, "post_arst");

    // Randomized operands against plain integer addition.
    for (int i = 0; i < 24; i++)
      run_add(8, 8'($urandom), 8'($urandom), 1'($urandom_range(1)), bit'(i % 2), "rand8");

    // Exhaustive 4-bit sweep.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          run_add(4, 8'(x), 8'(y), 1'(c), 1'b0, "exh4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder built around the one-bit full-adder cell; it adds two WIDTH-bit operands one bit per clock, LSB first.
- A single full-adder evaluation is reused every cycle, with a registered carry between bits.
- It is the sequential stage that sits directly on top of the full-adder cell. It sequences the cell's inputs and captures its sum and carry outputs.
- Intended as a low-area adder for datapaths that can tolerate multi-cycle latency.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request to begin an addition; sampled on rising clk edge
a  input  WIDTH  operand A; captured on the accepted-start edge
b  input  WIDTH  operand B; captured on the accepted-start edge
cin  input  1  carry-in; captured on the accepted-start edge
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse; sum and cout are valid and updated
sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH
cout  output  1  registered carry out of bit WIDTH-1

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- While rst=1:
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter are cleared.
- Reset asserted mid-operation aborts the addition. No done pulse is issued and sum/cout are cleared.
- After release, the block idles until the next start.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge is the accept edge: load A_sr<=a, B_sr<=b, c<=cin, cnt<=0; go to SHIFT.
- SHIFT:
  - busy=1. Each edge applies the full-adder cell to (A_sr[0], B_sr[0], c).
  - s = A_sr[0]^B_sr[0]^c; co = majority(A_sr[0], B_sr[0], c).
  - Register updates: A_sr and B_sr shift right by one; s enters S_sr at its MSB (S_sr shifts right); c<=co; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (the WIDTH-th shift), also load sum<=final S_sr and cout<=co, then go to DONE.
  - start is ignored in SHIFT.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - Next edge: if start=1, accept new operands exactly as in IDLE and go to SHIFT (back-to-back operation). Otherwise go to IDLE.
- Latency:
  - Accept edge at E0; shift edges are E1..E_WIDTH.
  - done is high in the cycle after E_WIDTH.
  - A new result therefore appears WIDTH edges after the accept edge.
  - Throughput is one addition per WIDTH+1 cycles.
- Output holding:
  - sum and cout change only on the completion edge (or reset).
  - They hold the last result through IDLE and through the next operation until its completion.
  - Partial bits never appear on sum.
- Operand changes on a, b or cin after the accept edge have no effect on the operation in progress.
- Arithmetic: {cout,sum} == a+b+cin exactly, for WIDTH+1-bit unsigned addition.
- Boundary cases:
  - All-ones + all-ones + cin=1 gives sum all-ones, cout=1.
  - Carry ripples across all WIDTH bits with no truncation.
- No combinational path from any input to any output.

Test Plan:
- WIDTH=8, rst pulse then a=0x5A, b=0x3C, cin=0, start for one cycle -> busy high 8 cycles, done pulse on 9th cycle after accept, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0, b=0, cin=0 -> sum=0x00, cout=0.
- During SHIFT, toggle start and change a/b -> ignored: still exactly one done, result matches operands captured at the accept edge; sum holds the previous value until completion.
- Hold start=1 continuously with a=0x10, b=0x20, then change to a=0x01, b=0x02 while busy -> done pulses every 9 cycles; first sum=0x30, next accepted in the DONE cycle; second sum=0x03.
- Assert rst asynchronously (mid-cycle) at the 4th shift of 0xAA+0x55 -> busy, done, sum and cout go to 0 immediately; no done pulse follows; the next start completes normally.
- WIDTH=4 instance, exhaustive a, b in 0..15 and cin in 0..1 -> {cout,sum} equals a+b+cin for all 512 cases, each done exactly 4 edges after accept.
